// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front end: scan codes, joystick bit
// layout, autofire rate encoding and the PS/2 key map.
package input_pkg;

   // PS/2 set-2 scan codes, player 0 (arrows need the E0 prefix)
   localparam logic [7:0] SC_P0_UP      = 8'h75;
   localparam logic [7:0] SC_P0_DOWN    = 8'h72;
   localparam logic [7:0] SC_P0_LEFT    = 8'h6B;
   localparam logic [7:0] SC_P0_RIGHT   = 8'h74;
   localparam logic [7:0] SC_P0_BTN0    = 8'h14;
   localparam logic [7:0] SC_P0_BTN1    = 8'h11;
   localparam logic [7:0] SC_P0_BTN2    = 8'h29;
   localparam logic [7:0] SC_P0_START   = 8'h16;
   localparam logic [7:0] SC_P0_COIN    = 8'h2E;
   localparam logic [7:0] SC_P0_PAUSE   = 8'h4D;
   localparam logic [7:0] SC_P0_SERVICE = 8'h46;

   // PS/2 set-2 scan codes, player 1 (no pause key)
   localparam logic [7:0] SC_P1_UP      = 8'h2D;
   localparam logic [7:0] SC_P1_DOWN    = 8'h2B;
   localparam logic [7:0] SC_P1_LEFT    = 8'h23;
   localparam logic [7:0] SC_P1_RIGHT   = 8'h34;
   localparam logic [7:0] SC_P1_BTN0    = 8'h1C;
   localparam logic [7:0] SC_P1_BTN1    = 8'h1B;
   localparam logic [7:0] SC_P1_BTN2    = 8'h15;
   localparam logic [7:0] SC_P1_START   = 8'h1E;
   localparam logic [7:0] SC_P1_COIN    = 8'h36;
   localparam logic [7:0] SC_P1_SERVICE = 8'h45;

   // Fixed joystick bit positions within a player's 32-bit word
   localparam int unsigned JOY_RIGHT = 0;
   localparam int unsigned JOY_LEFT  = 1;
   localparam int unsigned JOY_DOWN  = 2;
   localparam int unsigned JOY_UP    = 3;
   localparam int unsigned JOY_BTN0  = 4;

   // Button-count dependent joystick bit positions
   function automatic int unsigned joy_start(input int unsigned buttons);
      return JOY_BTN0 + buttons;
   endfunction

   function automatic int unsigned joy_coin(input int unsigned buttons);
      return JOY_BTN0 + buttons + 1;
   endfunction

   function automatic int unsigned joy_pause(input int unsigned buttons);
      return JOY_BTN0 + buttons + 2;
   endfunction

   function automatic int unsigned joy_service(input int unsigned buttons);
      return JOY_BTN0 + buttons + 3;
   endfunction

   // Number of meaningful low bits in each joystick word
   function automatic int unsigned joy_width(input int unsigned buttons);
      return JOY_BTN0 + buttons + 4;
   endfunction

   // Autofire half-period in prescaler ticks: 2^rate
   typedef enum logic [1:0] {
      AF_HALF_1T = 2'd0,
      AF_HALF_2T = 2'd1,
      AF_HALF_4T = 2'd2,
      AF_HALF_8T = 2'd3
   } af_rate_e;

   // Result of looking up one scan code
   typedef struct packed {
      logic       hit;
      logic [1:0] player;
      logic [3:0] ctrl;
   } key_hit_t;

   // Scan code to (player, joystick bit); buttons beyond the count are misses
   function automatic key_hit_t map_key(input logic [7:0] code, input logic ext,
                                        input int unsigned buttons);
      key_hit_t    m;
      logic        is_btn;
      int unsigned btn;
      m      = '{hit: 1'b1, player: 2'd0, ctrl: 4'd0};
      is_btn = 1'b0;
      btn    = 0;
      case (code)
         SC_P0_UP:      begin m.hit = ext; m.ctrl = 4'(JOY_UP);    end
         SC_P0_DOWN:    begin m.hit = ext; m.ctrl = 4'(JOY_DOWN);  end
         SC_P0_LEFT:    begin m.hit = ext; m.ctrl = 4'(JOY_LEFT);  end
         SC_P0_RIGHT:   begin m.hit = ext; m.ctrl = 4'(JOY_RIGHT); end
         SC_P0_BTN0:    begin is_btn = 1'b1; btn = 0; end
         SC_P0_BTN1:    begin is_btn = 1'b1; btn = 1; end
         SC_P0_BTN2:    begin is_btn = 1'b1; btn = 2; end
         SC_P0_START:   m.ctrl = 4'(joy_start(buttons));
         SC_P0_COIN:    m.ctrl = 4'(joy_coin(buttons));
         SC_P0_PAUSE:   m.ctrl = 4'(joy_pause(buttons));
         SC_P0_SERVICE: m.ctrl = 4'(joy_service(buttons));
         SC_P1_UP:      begin m.player = 2'd1; m.ctrl = 4'(JOY_UP);    end
         SC_P1_DOWN:    begin m.player = 2'd1; m.ctrl = 4'(JOY_DOWN);  end
         SC_P1_LEFT:    begin m.player = 2'd1; m.ctrl = 4'(JOY_LEFT);  end
         SC_P1_RIGHT:   begin m.player = 2'd1; m.ctrl = 4'(JOY_RIGHT); end
         SC_P1_BTN0:    begin m.player = 2'd1; is_btn = 1'b1; btn = 0; end
         SC_P1_BTN1:    begin m.player = 2'd1; is_btn = 1'b1; btn = 1; end
         SC_P1_BTN2:    begin m.player = 2'd1; is_btn = 1'b1; btn = 2; end
         SC_P1_START:   begin m.player = 2'd1; m.ctrl = 4'(joy_start(buttons));   end
         SC_P1_COIN:    begin m.player = 2'd1; m.ctrl = 4'(joy_coin(buttons));    end
         SC_P1_SERVICE: begin m.player = 2'd1; m.ctrl = 4'(joy_service(buttons)); end
         default:       m.hit = 1'b0;
      endcase
      if (is_btn) begin
         m.ctrl = 4'(JOY_BTN0 + btn);
         if (btn >= buttons) m.hit = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/arcade_input_if.sv
// Player-input bundle between hps_io (master) and the input front end (slave).
interface arcade_input_if #(
   parameter int unsigned PLAYERS = 2,
   parameter int unsigned BUTTONS = 3
);
   logic [10:0]                 ps2_key;
   logic [32*PLAYERS-1:0]       joystick;
   logic [PLAYERS*BUTTONS-1:0]  autofire_en;
   logic [1:0]                  autofire_rate;
   logic [PLAYERS-1:0]          up;
   logic [PLAYERS-1:0]          down;
   logic [PLAYERS-1:0]          left;
   logic [PLAYERS-1:0]          right;
   logic [PLAYERS*BUTTONS-1:0]  buttons;
   logic [PLAYERS-1:0]          start;
   logic [PLAYERS-1:0]          coin;
   logic [PLAYERS-1:0]          pause;
   logic [PLAYERS-1:0]          service;

   modport master (
      output ps2_key, joystick, autofire_en, autofire_rate,
      input  up, down, left, right, buttons, start, coin, pause, service
   );

   modport slave (
      input  ps2_key, joystick, autofire_en, autofire_rate,
      output up, down, left, right, buttons, start, coin, pause, service
   );
endinterface

// File: rtl/arcade_input_autofire_ch.sv
// One autofire channel: phase counter restarted on each press, gated output.
module autofire_ch
   import input_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     raw_i,
   input  logic     en_i,
   input  logic     tick_i,
   input  af_rate_e rate_i,
   output logic     fire_o
);

   logic [3:0] cnt_q, cnt_d;
   logic [3:0] phase_c;
   logic       raw_q;
   logic       fire_q, fire_d;
   logic       rise_c;

   assign rise_c = raw_i & ~raw_q;

   // Phase counter next state; a fresh press always starts in the high half
   always_comb begin
      cnt_d = cnt_q;
      if (rise_c)
         cnt_d = '0;
      else if (tick_i && raw_i)
         cnt_d = cnt_q + 4'd1;
      phase_c = rise_c ? 4'd0 : cnt_q;
      fire_d  = raw_i & (~en_i | ~phase_c[rate_i]);
   end

   // Channel state and registered output
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         raw_q  <= 1'b0;
         fire_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         raw_q  <= raw_i;
         fire_q <= fire_d;
      end
   end

   assign fire_o = fire_q;

endmodule

// File: rtl/arcade_input.sv
// Player-input front end: PS/2 key state merged with HPS joysticks, per-button
// autofire and a minimum-width coin pulse, all outputs registered.
module arcade_input
   import input_pkg::*;
#(
   parameter int unsigned PLAYERS      = 2,
   parameter int unsigned BUTTONS      = 3,
   parameter int unsigned COIN_CYCLES  = 1_000_000,
   parameter int unsigned AUTOFIRE_DIV = 400_000
) (
   input  logic           clk_sys,
   input  logic           rst_sys_n,
   arcade_input_if.slave  bus
);

   localparam int unsigned CW          = joy_width(BUTTONS);
   localparam int unsigned COIN_BIT    = joy_coin(BUTTONS);
   localparam int unsigned START_BIT   = joy_start(BUTTONS);
   localparam int unsigned PAUSE_BIT   = joy_pause(BUTTONS);
   localparam int unsigned SERVICE_BIT = joy_service(BUTTONS);
   localparam int unsigned COIN_W      = $clog2(COIN_CYCLES);
   localparam int unsigned PRE_W       = $clog2(AUTOFIRE_DIV);
   localparam logic [COIN_W-1:0] COIN_LOAD = COIN_W'(COIN_CYCLES - 1);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(AUTOFIRE_DIV - 1);

   logic             toggle_q;
   logic             primed_q;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick_c;
   logic             ev_c;
   key_hit_t         hit_c;
   logic [15:0]      ctrl_onehot_c;
   af_rate_e         rate_c;

   assign rate_c = af_rate_e'(bus.autofire_rate);

   // PS/2 event detect and key lookup shared by all players
   always_comb begin
      ev_c          = primed_q && (bus.ps2_key[10] != toggle_q);
      hit_c         = map_key(bus.ps2_key[7:0], bus.ps2_key[8], BUTTONS);
      ctrl_onehot_c = 16'd1 << hit_c.ctrl;
   end

   // Autofire prescaler: one-cycle tick at wrap
   always_comb begin
      tick_c = (pre_q == PRE_LAST);
      pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
   end

   // Toggle tracking, priming and prescaler state
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         toggle_q <= 1'b0;
         primed_q <= 1'b0;
         pre_q    <= '0;
      end else begin
         toggle_q <= bus.ps2_key[10];
         primed_q <= 1'b1;
         pre_q    <= pre_d;
      end
   end

   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic [CW-1:0]     key_q, key_d;
      logic [CW-1:0]     sel_c;
      logic [CW-1:0]     raw_c;
      logic [COIN_W-1:0] coin_cnt_q, coin_cnt_d;
      logic              coin_raw_q;
      logic              up_q, down_q, left_q, right_q;
      logic              start_q, coin_q, pause_q, service_q;
      logic              unused_joy_hi;

      assign unused_joy_hi = ^bus.joystick[32*p+CW +: 32-CW];
      assign raw_c         = key_q | bus.joystick[32*p +: CW];

      // Held-key state update for this player
      always_comb begin
         sel_c = '0;
         if (ev_c && hit_c.hit && (hit_c.player == 2'(p)))
            sel_c = ctrl_onehot_c[CW-1:0];
         key_d = (key_q & ~sel_c) | (sel_c & {CW{bus.ps2_key[9]}});
      end

      // Coin stretch counter: loads only from idle, so extra edges never extend
      always_comb begin
         coin_cnt_d = coin_cnt_q;
         if (raw_c[COIN_BIT] && !coin_raw_q && (coin_cnt_q == '0))
            coin_cnt_d = COIN_LOAD;
         else if (coin_cnt_q != '0)
            coin_cnt_d = coin_cnt_q - COIN_W'(1);
      end

      // Key registers, coin stretcher and registered pass-through outputs
      always_ff @(posedge clk_sys or negedge rst_sys_n) begin
         if (!rst_sys_n) begin
            key_q      <= '0;
            coin_cnt_q <= '0;
            coin_raw_q <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            start_q    <= 1'b0;
            coin_q     <= 1'b0;
            pause_q    <= 1'b0;
            service_q  <= 1'b0;
         end else begin
            key_q      <= key_d;
            coin_cnt_q <= coin_cnt_d;
            coin_raw_q <= raw_c[COIN_BIT];
            up_q       <= raw_c[JOY_UP];
            down_q     <= raw_c[JOY_DOWN];
            left_q     <= raw_c[JOY_LEFT];
            right_q    <= raw_c[JOY_RIGHT];
            start_q    <= raw_c[START_BIT];
            coin_q     <= (coin_cnt_q != '0) | raw_c[COIN_BIT];
            pause_q    <= raw_c[PAUSE_BIT];
            service_q  <= raw_c[SERVICE_BIT];
         end
      end

      assign bus.up[p]      = up_q;
      assign bus.down[p]    = down_q;
      assign bus.left[p]    = left_q;
      assign bus.right[p]   = right_q;
      assign bus.start[p]   = start_q;
      assign bus.coin[p]    = coin_q;
      assign bus.pause[p]   = pause_q;
      assign bus.service[p] = service_q;

      for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
         logic fire_w;

         autofire_ch u_af (
            .clk_i  (clk_sys),
            .rst_ni (rst_sys_n),
            .raw_i  (raw_c[JOY_BTN0+b]),
            .en_i   (bus.autofire_en[p*BUTTONS+b]),
            .tick_i (tick_c),
            .rate_i (rate_c),
            .fire_o (fire_w)
         );

         assign bus.buttons[p*BUTTONS+b] = fire_w;
      end
   end

endmodule
